// File: rtl/arp_rx_parser_pkg.sv
// arp_pkg: shared constants, field offsets and the parser state type for arp_rx_parser.
// Latency: n/a. Backpressure: n/a.
// Contents: Ethernet/ARP field constants, byte offsets and byte-select helpers.
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [15:0] OPER_REQ      = 16'd1;
  localparam logic [15:0] OPER_REPLY    = 16'd2;
  localparam logic [7:0]  HLEN_ETH      = 8'd6;
  localparam logic [7:0]  PLEN_IPV4     = 8'd4;
  localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

  localparam int ARP_FRAME_LEN = 42;

  // Byte offsets from the first byte of the Ethernet header.
  localparam logic [5:0] OFF_DST     = 6'd0;
  localparam logic [5:0] OFF_SRC     = 6'd6;
  localparam logic [5:0] OFF_ETYPE   = 6'd12;
  localparam logic [5:0] OFF_HTYPE   = 6'd14;
  localparam logic [5:0] OFF_PTYPE   = 6'd16;
  localparam logic [5:0] OFF_HLEN    = 6'd18;
  localparam logic [5:0] OFF_PLEN    = 6'd19;
  localparam logic [5:0] OFF_OPER_HI = 6'd20;
  localparam logic [5:0] OFF_OPER_LO = 6'd21;
  localparam logic [5:0] OFF_SHA     = 6'd22;
  localparam logic [5:0] OFF_SPA     = 6'd28;
  localparam logic [5:0] OFF_THA     = 6'd32;
  localparam logic [5:0] OFF_TPA     = 6'd38;
  localparam logic [5:0] OFF_LAST    = 6'd41;

  typedef enum logic [1:0] {IDLE, HDR, PAD, DONE} arp_rx_state_t;

  // Expected value of the fixed header bytes 12..20 (byte 21 is checked separately).
  function automatic logic [7:0] fixed_hdr_byte(input logic [5:0] idx);
    case (idx)
      OFF_ETYPE:        return ETHERTYPE_ARP[15:8];
      OFF_ETYPE + 6'd1: return ETHERTYPE_ARP[7:0];
      OFF_HTYPE:        return HTYPE_ETH[15:8];
      OFF_HTYPE + 6'd1: return HTYPE_ETH[7:0];
      OFF_PTYPE:        return PTYPE_IPV4[15:8];
      OFF_PTYPE + 6'd1: return PTYPE_IPV4[7:0];
      OFF_HLEN:         return HLEN_ETH;
      OFF_PLEN:         return PLEN_IPV4;
      default:          return OPER_REQ[15:8];
    endcase
  endfunction

  // Big-endian byte i of a MAC address (i = 0 is the MSB, first on the wire).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
    case (i)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

  // Big-endian byte i of an IPv4 address.
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] i);
    case (i)
      2'd0:    return ip[31:24];
      2'd1:    return ip[23:16];
      2'd2:    return ip[15:8];
      default: return ip[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arp_rx_parser_if.sv
// arp_rx_parser_if: byte-wide AXI-Stream link from the MAC RX path.
// Latency: n/a. Backpressure: tready driven by the sink (slave modport).
// Signals: tdata/tvalid/tlast/tuser from master, tready from slave.
interface arp_rx_parser_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/arp_rx_parser_stats.sv
// arp_rx_stats: wrapping 16-bit counters of published and dropped ARP frames (ARP_RX_STATS_EN builds only).
// Latency: counters update on the clock edge that sees the increment strobe.
// Backpressure: none. Ports: aclk, aresetn, ok_inc, drop_inc -> stat_rx_ok, stat_rx_drop.
module arp_rx_stats (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        ok_inc,
  input  logic        drop_inc,
  output logic [15:0] stat_rx_ok,
  output logic [15:0] stat_rx_drop
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_rx_ok   <= '0;
      stat_rx_drop <= '0;
    end else begin
      if (ok_inc)   stat_rx_ok   <= stat_rx_ok + 16'd1;
      if (drop_inc) stat_rx_drop <= stat_rx_drop + 16'd1;
    end
  end

endmodule

// File: rtl/arp_rx_parser.sv
// arp_rx_parser: parses Ethernet II + ARP frames from the MAC RX stream and publishes SHA/SPA to arp_cache.
// Latency: arp_mac_s_addr_valid pulses 1 cycle after the tlast beat. Backpressure: none, tready=1 after reset.
// Ports: aclk, aresetn, mac/ip config, s_axis (slave), arp_* / eth_mac_s_addr outputs;
// macro ARP_RX_STATS_EN adds stat_rx_ok / stat_rx_drop.
module arp_rx_parser
  import arp_pkg::*;
#(
  parameter bit ACCEPT_BCAST = 1'b1,
  parameter bit CHECK_TPA    = 1'b0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [47:0]           mac_config_addr_in,
  input  logic [31:0]           ip_config_addr_in,
  arp_rx_parser_if.slave        s_axis,
  output logic [47:0]           arp_mac_s_addr,
  output logic [31:0]           arp_ip_s_addr,
  output logic                  arp_mac_s_addr_valid,
  output logic                  arp_oper_req,
  output logic                  arp_tpa_match,
`ifdef ARP_RX_STATS_EN
  output logic [15:0]           stat_rx_ok,
  output logic [15:0]           stat_rx_drop,
`endif
  output logic [47:0]           eth_mac_s_addr
);

  arp_rx_state_t state;
  logic [5:0]    cnt;
  logic          tready_r;

  // Sticky per-frame check flags; dst has two so own-MAC and broadcast match independently.
  logic own_ok, bc_ok, hdr_ok, tpa_ok;
  logic own_n, bc_n, hdr_n, tpa_n;

  // Shadow captures; only copied to the outputs when the frame publishes.
  logic [47:0] src_sh, sha_sh;
  logic [31:0] spa_sh;
  logic        oper_sh;

  logic        beat, first, pub_ok, frame_end, runt_end;
  logic [5:0]  idx;
  logic [7:0]  byte_in;

  assign s_axis.tready = tready_r;
  assign beat    = s_axis.tvalid & tready_r;
  assign byte_in = s_axis.tdata;
  // In IDLE and DONE the incoming beat is byte 0 of a new frame.
  assign first   = (state == IDLE) || (state == DONE);
  assign idx     = first ? OFF_DST : cnt;

  always_comb begin
    own_n = first ? 1'b1 : own_ok;
    bc_n  = first ? 1'b1 : bc_ok;
    hdr_n = first ? 1'b1 : hdr_ok;
    tpa_n = first ? 1'b1 : tpa_ok;
    if (beat) begin
      if (idx < OFF_SRC) begin
        own_n = own_n & (byte_in == mac_byte(mac_config_addr_in, idx[2:0]));
        bc_n  = bc_n  & (byte_in == MAC_BCAST[7:0]);
      end
      if (idx >= OFF_ETYPE && idx <= OFF_OPER_HI)
        hdr_n = hdr_n & (byte_in == fixed_hdr_byte(idx));
      if (idx == OFF_OPER_LO)
        hdr_n = hdr_n & ((byte_in == OPER_REQ[7:0]) || (byte_in == OPER_REPLY[7:0]));
      if (idx >= OFF_TPA && idx <= OFF_LAST)
        tpa_n = tpa_n & (byte_in == ip_byte(ip_config_addr_in, 2'(idx - OFF_TPA)));
    end
  end

  // Flags above already include the current (tlast) byte, so the decision is ready on the tlast edge.
  assign pub_ok    = hdr_n & (own_n | (ACCEPT_BCAST & bc_n)) & ~s_axis.tuser & (~CHECK_TPA | tpa_n);
  assign frame_end = beat & s_axis.tlast & (((state == HDR) && (idx == OFF_LAST)) || (state == PAD));
  assign runt_end  = beat & s_axis.tlast & (first || ((state == HDR) && (idx != OFF_LAST)));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                <= IDLE;
      cnt                  <= '0;
      tready_r             <= 1'b0;
      own_ok               <= 1'b0;
      bc_ok                <= 1'b0;
      hdr_ok               <= 1'b0;
      tpa_ok               <= 1'b0;
      src_sh               <= '0;
      sha_sh               <= '0;
      spa_sh               <= '0;
      oper_sh              <= 1'b0;
      arp_mac_s_addr       <= '0;
      arp_ip_s_addr        <= '0;
      arp_mac_s_addr_valid <= 1'b0;
      arp_oper_req         <= 1'b0;
      arp_tpa_match        <= 1'b0;
      eth_mac_s_addr       <= '0;
    end else begin
      tready_r             <= 1'b1;
      arp_mac_s_addr_valid <= 1'b0;

      if (beat) begin
        own_ok <= own_n;
        bc_ok  <= bc_n;
        hdr_ok <= hdr_n;
        tpa_ok <= tpa_n;
        cnt    <= (idx >= OFF_LAST) ? 6'(ARP_FRAME_LEN) : idx + 6'd1;
        if (idx >= OFF_SRC && idx < OFF_ETYPE) src_sh <= {src_sh[39:0], byte_in};
        if (idx >= OFF_SHA && idx < OFF_SPA)   sha_sh <= {sha_sh[39:0], byte_in};
        if (idx >= OFF_SPA && idx < OFF_THA)   spa_sh <= {spa_sh[23:0], byte_in};
        if (idx == OFF_OPER_LO)                oper_sh <= (byte_in == OPER_REQ[7:0]);
      end

      case (state)
        IDLE, DONE: state <= (beat && !s_axis.tlast) ? HDR : IDLE;
        HDR: begin
          if (beat) begin
            if (idx == OFF_LAST)   state <= s_axis.tlast ? DONE : PAD;
            else if (s_axis.tlast) state <= IDLE;
          end
        end
        PAD:     if (beat && s_axis.tlast) state <= DONE;
        default: state <= IDLE;
      endcase

      if (frame_end && pub_ok) begin
        arp_mac_s_addr_valid <= 1'b1;
        arp_mac_s_addr       <= sha_sh;
        arp_ip_s_addr        <= spa_sh;
        arp_oper_req         <= oper_sh;
        arp_tpa_match        <= tpa_n;
        eth_mac_s_addr       <= src_sh;
      end
    end
  end

`ifdef ARP_RX_STATS_EN
  logic ok_inc, drop_inc;
  assign ok_inc   = frame_end & pub_ok;
  assign drop_inc = (frame_end & ~pub_ok) | runt_end;

  arp_rx_stats u_stats (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .ok_inc       (ok_inc),
    .drop_inc     (drop_inc),
    .stat_rx_ok   (stat_rx_ok),
    .stat_rx_drop (stat_rx_drop)
  );
`endif

endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Byte-wide AXI-Stream sink on the MAC RX path; parses Ethernet II + ARP (IPv4 over Ethernet) frames.
- Checks the header fields, then captures the sender MAC/IP and frame source MAC.
- Emits a one-cycle valid pulse into arp_cache (arp_mac_s_addr / arp_ip_s_addr / arp_mac_s_addr_valid).
- Non-ARP or malformed frames are consumed silently.

Parameters:
- ACCEPT_BCAST, 1, 1: accept destination MAC FF:FF:FF:FF:FF:FF in addition to own MAC; 0: own MAC only.
- CHECK_TPA, 0, 1: publish only when target protocol address equals ip_config_addr_in; 0: publish every valid ARP.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- mac_config_addr_in  in  48  own MAC, sampled live
- ip_config_addr_in  in  32  own IP, sampled live
- s_axis_tdata  in  8  frame byte, wire order
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  sink ready
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  MAC error flag, meaningful on the tlast beat
- arp_mac_s_addr  out  48  sender hardware address (SHA)
- arp_ip_s_addr  out  32  sender protocol address (SPA)
- arp_mac_s_addr_valid  out  1  1-cycle pulse; SHA/SPA valid
- arp_oper_req  out  1  1 = request (oper 1), 0 = reply (oper 2); qualified by valid
- arp_tpa_match  out  1  TPA == ip_config_addr_in; qualified by valid
- eth_mac_s_addr  out  48  Ethernet source MAC of the same frame; qualified by valid

Behaviour:
- Clock and reset: single clock aclk; reset aresetn is asynchronous, active-low.
- Reset values:
  - all outputs 0, except s_axis_tready, which is 0 during reset and 1 from the first clock after release;
  - state IDLE, byte counter 0.
- Flow control: s_axis_tready stays 1 after reset (no backpressure). A beat is transferred when tvalid is high; tvalid gaps are allowed anywhere in a frame.
- Byte counter: 6 bits, counts transferred bytes 0..41, saturates at 42.
- Field offsets:
  - dst MAC 0-5; src MAC 6-11; ethertype 12-13 = 0x0806.
  - htype 14-15 = 0x0001; ptype 16-17 = 0x0800; hlen 18 = 6; plen 19 = 4.
  - oper 20-21 ∈ {1,2}.
  - SHA 22-27; SPA 28-31; THA 32-37 (ignored); TPA 38-41.
  - All multi-byte fields are big-endian (first byte = MSB).
- Field checks: done byte-by-byte as bytes arrive; any mismatch clears a sticky ok flag. No full-frame buffering.
- Dst MAC check passes if the address equals mac_config_addr_in, or is broadcast when ACCEPT_BCAST=1.
- States:
  - IDLE: the first transferred beat is byte 0 → HDR. A tlast on byte 0 → IDLE, no output.
  - HDR: capture and check fields.
    - tlast before byte 41 → IDLE, no output (runt).
    - Byte 41 with tlast → DONE.
    - Byte 41 without tlast → PAD.
  - PAD: discard bytes (Ethernet padding and FCS if present) until tlast → DONE.
  - DONE: exactly one cycle, then IDLE. Publish if ok and the tlast-beat tuser=0 and (CHECK_TPA=0 or TPA match).
    - Publish drives arp_mac_s_addr_valid=1 for one cycle, with SHA, SPA, oper, tpa_match and src MAC updated in the same cycle.
- DONE accepts a byte: a byte arriving in the DONE cycle is treated as byte 0 of the next frame, giving zero-gap back-to-back frames.
- Latency: valid pulse occurs 1 cycle after the tlast beat.
- Output data: holds its last published value between pulses. A dropped frame never modifies the outputs; captures go to shadow registers and are copied on publish.
- Length: frames longer than 42 bytes are accepted; the count saturates.
- Reset mid-frame: outputs and state return to reset values; the remainder of the interrupted frame is parsed as a new frame and fails the ethertype/length checks naturally.
- Config changes: a change to the config inputs mid-frame affects only the bytes compared after the change.

Optional Feature:
- Macro: ARP_RX_STATS_EN.
- Defined: adds output ports stat_rx_ok (16) and stat_rx_drop (16).
  - stat_rx_ok counts published frames.
  - stat_rx_drop counts frames that reached tlast without publishing.
  - Both counters wrap at 0xFFFF→0, reset to 0, and increment in the DONE/IDLE-runt cycle.
- Undefined: the ports and counters are absent; parse behaviour is identical.

Decomposition:
- Package arp_pkg:
  - constants ETHERTYPE_ARP=16'h0806, HTYPE_ETH=16'h0001, PTYPE_IPV4=16'h0800;
  - OPER_REQ=16'd1, OPER_REPLY=16'd2; MAC_BCAST=48'hFFFF_FFFF_FFFF;
  - ARP_FRAME_LEN=42, field offset localparams;
  - enum arp_rx_state_t {IDLE,HDR,PAD,DONE}.
- Core logic: no sub-module.
- Statistics: under the macro, sub-module arp_rx_stats holds the two counters.

Test Plan:
- Broadcast request:
  - Stimulus: dst FF.., src 02:00:00:00:00:01, oper 1, SHA 02:00:00:00:00:01, SPA 192.168.1.10, TPA = own IP, 18 pad bytes.
  - Response: one valid pulse 1 cycle after tlast; arp_mac_s_addr=48'h020000000001, arp_ip_s_addr=32'hC0A8010A, oper_req=1, tpa_match=1.
- Unicast reply to own MAC, oper 2, with tvalid deasserted every other cycle → single pulse, oper_req=0, correct SHA/SPA.
- Ethertype 0x0800 frame, 60 bytes → no pulse; outputs unchanged from the previous publish; stat_rx_drop +1 under the macro.
- Runt and error frames:
  - Runt: tlast at byte 30 → no pulse.
  - Error: valid ARP with tuser=1 on tlast → no pulse.
  - A following good frame placed back-to-back (byte 0 in the DONE cycle) → pulse.
- Filter checks:
  - ACCEPT_BCAST=0 with broadcast dst → no pulse.
  - CHECK_TPA=1 with TPA ≠ own IP → no pulse.
  - CHECK_TPA=1 with TPA = own IP → pulse.
- Reset mid-frame: assert aresetn=0 at byte 25 → outputs all 0 asynchronously, no pulse; the next complete ARP frame is parsed correctly.
